// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared control-bit indices, FSM states and defaults for the MEM stage
package mem_stage_pkg;

    localparam int MEM_EN   = 0;
    localparam int MEM_WR   = 1;
    localparam int MEM_BYTE = 2;
    localparam int MEM_SGN  = 3;

    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_e;

    function automatic logic [31:0] replicate_byte(input logic [7:0] b);
        return {4{b}};
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane steering for stores and lane extraction for loads
module mem_lane_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  st_lane_i,
    input  logic        st_byte_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    input  logic [1:0]  ld_lane_i,
    input  logic        ld_byte_i,
    input  logic        ld_sgn_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] ld_data_o
);

    logic [7:0] ld_b;

    always_comb begin
        be_o    = st_byte_i ? (4'b0001 << st_lane_i) : 4'b1111;
        wdata_o = st_byte_i ? replicate_byte(st_data_i[7:0]) : st_data_i;

        case (ld_lane_i)
            2'd0:    ld_b = rdata_i[7:0];
            2'd1:    ld_b = rdata_i[15:8];
            2'd2:    ld_b = rdata_i[23:16];
            default: ld_b = rdata_i[31:24];
        endcase

        if (ld_byte_i) begin
            ld_data_o = {{24{ld_sgn_i & ld_b[7]}}, ld_b};
        end else begin
            ld_data_o = rdata_i;
        end
    end

endmodule

// File: rtl/mem_stage_access_unit.sv
// rtl/mem_stage_access_unit.sv - MEM stage: data-memory handshake, pipeline stall and MEM/WB register
module mem_stage_access_unit
    import mem_stage_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            mem_control_in,
    input  logic [3:0]            wb_control_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] store_data_in,
    input  logic [3:0]            rd_in,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  stall_out,
    output logic                  wb_valid,
    output logic [3:0]            wb_control_out,
    output logic [DATA_WIDTH-1:0] result_out,
    output logic [3:0]            rd_out,
    output logic                  align_fault,
    output logic                  bus_error
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [3:0]            be_q, be_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  byte_q, byte_d;
    logic                  sgn_q, sgn_d;
    logic [3:0]            ctl_q, ctl_d;
    logic [3:0]            rd_q, rd_d;

    logic                  wb_valid_q, wb_valid_d;
    logic [3:0]            wb_ctl_q, wb_ctl_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [3:0]            rd_out_q, rd_out_d;
    logic                  align_q, align_d;
    logic                  buserr_q, buserr_d;

    logic                  access, misaligned, start, in_req, timeout_hit;
    logic [3:0]            st_be;
    logic [31:0]           st_wdata, ld_data;

    assign access      = mem_control_in[MEM_EN];
    assign misaligned  = access & ~mem_control_in[MEM_BYTE] & (addr_in[1:0] != 2'b00);
    assign start       = access & ~misaligned;
    assign in_req      = (state_q == REQ);
    assign timeout_hit = (TIMEOUT_CYCLES > 0) && in_req && !mem_ready && (cnt_q == CNT_LAST);
    assign stall_out   = (~in_req & start) | (in_req & ~mem_ready & ~timeout_hit);

    // Request fields are gated by state so they read zero outside an access and on reset.
    assign mem_req   = in_req;
    assign mem_we    = in_req & we_q;
    assign mem_be    = in_req ? be_q : 4'b0000;
    assign mem_addr  = in_req ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign mem_wdata = in_req ? wdata_q : '0;

    assign wb_valid       = wb_valid_q;
    assign wb_control_out = wb_ctl_q;
    assign result_out     = result_q;
    assign rd_out         = rd_out_q;
    assign align_fault    = align_q;
    assign bus_error      = buserr_q;

    mem_lane_align u_lane (
        .st_lane_i (addr_in[1:0]),
        .st_byte_i (mem_control_in[MEM_BYTE]),
        .st_data_i (store_data_in),
        .be_o      (st_be),
        .wdata_o   (st_wdata),
        .ld_lane_i (addr_q[1:0]),
        .ld_byte_i (byte_q),
        .ld_sgn_i  (sgn_q),
        .rdata_i   (mem_rdata),
        .ld_data_o (ld_data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        we_d       = we_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        byte_d     = byte_q;
        sgn_d      = sgn_q;
        ctl_d      = ctl_q;
        rd_d       = rd_q;
        wb_valid_d = 1'b0;
        wb_ctl_d   = 4'b0000;
        result_d   = '0;
        rd_out_d   = 4'b0000;
        align_d    = 1'b0;
        buserr_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = addr_in;
                    we_d    = mem_control_in[MEM_WR];
                    be_d    = st_be;
                    wdata_d = st_wdata;
                    byte_d  = mem_control_in[MEM_BYTE];
                    sgn_d   = mem_control_in[MEM_SGN];
                    ctl_d   = wb_control_in;
                    rd_d    = rd_in;
                    cnt_d   = '0;
                    state_d = REQ;
                end else if (misaligned) begin
                    align_d = 1'b1;
                end else begin
                    wb_valid_d = 1'b1;
                    wb_ctl_d   = wb_control_in;
                    result_d   = DATA_WIDTH'(addr_in);
                    rd_out_d   = rd_in;
                end
            end
            REQ: begin
                if (mem_ready) begin
                    wb_valid_d = 1'b1;
                    wb_ctl_d   = ctl_q;
                    rd_out_d   = rd_q;
                    result_d   = we_q ? DATA_WIDTH'(addr_q) : ld_data;
                    state_d    = IDLE;
                end else if (timeout_hit) begin
                    buserr_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            be_q       <= 4'b0000;
            wdata_q    <= '0;
            byte_q     <= 1'b0;
            sgn_q      <= 1'b0;
            ctl_q      <= 4'b0000;
            rd_q       <= 4'b0000;
            wb_valid_q <= 1'b0;
            wb_ctl_q   <= 4'b0000;
            result_q   <= '0;
            rd_out_q   <= 4'b0000;
            align_q    <= 1'b0;
            buserr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            byte_q     <= byte_d;
            sgn_q      <= sgn_d;
            ctl_q      <= ctl_d;
            rd_q       <= rd_d;
            wb_valid_q <= wb_valid_d;
            wb_ctl_q   <= wb_ctl_d;
            result_q   <= result_d;
            rd_out_q   <= rd_out_d;
            align_q    <= align_d;
            buserr_q   <= buserr_d;
        end
    end

endmodule
